// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and op priority encoder for the PC/call-stack block
package pc_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BRANCH,
        OP_LOAD,
        OP_CALL,
        OP_RET,
        OP_IRQ
    } pc_op_e;

    // Fixed priority: stall > irq_take > ret > call > load > branch_rel > inc > hold.
    // clr sits above all of these and is handled by the registers directly.
    function automatic pc_op_e encode_op(
        input logic stall,
        input logic irq_take,
        input logic ret,
        input logic call,
        input logic load,
        input logic branch_rel,
        input logic inc
    );
        pc_op_e op;
        if (stall)           op = OP_HOLD;
        else if (irq_take)   op = OP_IRQ;
        else if (ret)        op = OP_RET;
        else if (call)       op = OP_CALL;
        else if (load)       op = OP_LOAD;
        else if (branch_rel) op = OP_BRANCH;
        else if (inc)        op = OP_INC;
        else                 op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - circular return-address LIFO with sticky overflow/underflow flags
module ret_addr_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ADDR_W-1:0]          push_data_i,
    output logic [ADDR_W-1:0]          top_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full, empty;

    assign full   = (cnt_q == CNT_MAX);
    assign empty  = (cnt_q == '0);
    assign wr_ptr = ptr_q + PTR_ONE;

    // Pointer, count and sticky-flag next state; pushing when full wraps over the oldest entry.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_i) begin
            ptr_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (push_i) begin
            ptr_d = wr_ptr;
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CNT_ONE;
        end else if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PTR_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Control registers; async reset empties the stack but leaves RAM contents alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage, written one slot above the current top on every push.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr] <= push_data_i;
    end

    assign top_o   = empty ? '0 : mem_q[ptr_q];
    assign cnt_o   = cnt_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with branch/call/return/interrupt and return stack
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 DEPTH     = 8,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  IRQ_VEC   = ADDR_W'(1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_i,
    input  logic                       stall_i,
    input  logic                       inc_i,
    input  logic                       load_i,
    input  logic                       branch_rel_i,
    input  logic                       call_i,
    input  logic                       ret_i,
    input  logic                       irq_take_i,
    input  logic [ADDR_W-1:0]          new_addr_i,
    input  logic [ADDR_W-1:0]          offset_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [ADDR_W-1:0]          stack_top_o,
    output logic [$clog2(DEPTH+1)-1:0] stack_cnt_o,
    output logic                       stack_full_o,
    output logic                       stack_empty_o,
    output logic                       ovf_err_o,
    output logic                       unf_err_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    pc_op_e            op;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic              push, pop;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] top;
    logic              empty;

    assign op       = encode_op(stall_i, irq_take_i, ret_i, call_i, load_i, branch_rel_i, inc_i);
    assign pc_plus1 = pc_q + ADDR_ONE;

    // Stack strobes: call pushes the return address, interrupt entry pushes the interrupted pc.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_q;
        if (!clr_i) begin
            unique case (op)
                OP_CALL: begin
                    push      = 1'b1;
                    push_data = pc_plus1;
                end
                OP_IRQ:  push = 1'b1;
                OP_RET:  pop  = 1'b1;
                default: ;
            endcase
        end
    end

    // Next pc; a return on an empty stack leaves the pc where it is.
    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = RESET_VEC;
        end else begin
            unique case (op)
                OP_INC:    pc_d = pc_plus1;
                OP_BRANCH: pc_d = pc_q + offset_i;
                OP_LOAD:   pc_d = new_addr_i;
                OP_CALL:   pc_d = new_addr_i;
                OP_RET:    if (!empty) pc_d = top;
                OP_IRQ:    pc_d = IRQ_VEC;
                default:   pc_d = pc_q;
            endcase
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_VEC;
        else       pc_q <= pc_d;
    end

    ret_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (clr_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_data),
        .top_o       (top),
        .cnt_o       (stack_cnt_o),
        .full_o      (stack_full_o),
        .empty_o     (empty),
        .ovf_o       (ovf_err_o),
        .unf_o       (unf_err_o)
    );

    assign pc_o          = pc_q;
    assign stack_top_o   = top;
    assign stack_empty_o = empty;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb/tb_pc_call_stack.sv - directed self-checking bench for pc_call_stack
module tb_pc_call_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr, stall, inc, load, branch_rel, call, ret, irq_take;
    logic [11:0] new_addr, offset;
    logic [11:0] pc, stack_top;
    logic [3:0]  stack_cnt;
    logic        stack_full, stack_empty, ovf_err, unf_err;

    int vectors = 0;
    int miscompares = 0;

    pc_call_stack #(
        .ADDR_W    (12),
        .DEPTH     (8),
        .RESET_VEC (12'h000),
        .IRQ_VEC   (12'h001)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clr_i         (clr),
        .stall_i       (stall),
        .inc_i         (inc),
        .load_i        (load),
        .branch_rel_i  (branch_rel),
        .call_i        (call),
        .ret_i         (ret),
        .irq_take_i    (irq_take),
        .new_addr_i    (new_addr),
        .offset_i      (offset),
        .pc_o          (pc),
        .stack_top_o   (stack_top),
        .stack_cnt_o   (stack_cnt),
        .stack_full_o  (stack_full),
        .stack_empty_o (stack_empty),
        .ovf_err_o     (ovf_err),
        .unf_err_o     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr = 0; stall = 0; inc = 0; load = 0; branch_rel = 0;
        call = 0; ret = 0; irq_take = 0;
    endtask

    initial begin
        logic [11:0] exp_ret;
        reset = 1;
        clr = 0; stall = 0; inc = 0; load = 0; branch_rel = 0;
        call = 0; ret = 0; irq_take = 0;
        new_addr = '0; offset = '0;
        @(posedge clk); @(posedge clk); #1;

        // 1: reset state, increment and wrap
        check("rst_pc", pc, 12'h000);
        check("rst_cnt", stack_cnt, 4'd0);
        check("rst_top", stack_top, 12'h000);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_errs", {ovf_err, unf_err}, 2'b00);
        reset = 0;
        inc = 1; step(); inc = 1; step(); inc = 1; step();
        check("inc3_pc", pc, 12'h003);
        load = 1; new_addr = 12'hFFF; step();
        check("load_fff", pc, 12'hFFF);
        inc = 1; step();
        check("inc_wrap", pc, 12'h000);

        // 2: call and return
        load = 1; new_addr = 12'h010; step();
        call = 1; new_addr = 12'h200; step();
        check("call_pc", pc, 12'h200);
        check("call_top", stack_top, 12'h011);
        check("call_cnt", stack_cnt, 4'd1);
        check("call_empty", stack_empty, 1'b0);
        ret = 1; step();
        check("ret_pc", pc, 12'h011);
        check("ret_cnt", stack_cnt, 4'd0);
        check("ret_empty", stack_empty, 1'b1);
        check("ret_top", stack_top, 12'h000);

        // 3: relative branch and priority
        load = 1; new_addr = 12'h005; step();
        branch_rel = 1; offset = 12'hFFE; step();
        check("branch_back", pc, 12'h003);
        load = 1; inc = 1; new_addr = 12'h0AB; step();
        check("load_over_inc", pc, 12'h0AB);
        call = 1; new_addr = 12'h300; step();
        check("call2_top", stack_top, 12'h0AC);
        ret = 1; call = 1; new_addr = 12'h400; step();
        check("ret_over_call_pc", pc, 12'h0AC);
        check("ret_over_call_cnt", stack_cnt, 4'd0);
        check("ret_over_call_unf", unf_err, 1'b0);
        load = 1; new_addr = 12'hFFF; step();
        call = 1; new_addr = 12'h050; step();
        check("call_wrap_top", stack_top, 12'h000);
        ret = 1; step();
        check("ret_wrap_pc", pc, 12'h000);

        // 4: overflow and underflow with DEPTH=8
        load = 1; new_addr = 12'h020; step();
        for (int k = 0; k < 9; k++) begin
            call = 1; new_addr = 12'h030 + 12'(k * 16); step();
            check("ovf_call_cnt", stack_cnt, (k < 8) ? k + 1 : 8);
            if (k == 7) check("ovf_not_yet", ovf_err, 1'b0);
        end
        check("ovf_full", stack_full, 1'b1);
        check("ovf_err", ovf_err, 1'b1);
        check("ovf_top", stack_top, 12'h0A1);
        check("ovf_pc", pc, 12'h0B0);
        for (int k = 8; k >= 1; k--) begin
            ret = 1; step();
            exp_ret = 12'h021 + 12'(k * 16);
            check("ovf_ret_pc", pc, exp_ret);
            check("ovf_ret_cnt", stack_cnt, k - 1);
        end
        check("unf_pre", unf_err, 1'b0);
        ret = 1; step();
        check("unf_pc_hold", pc, 12'h031);
        check("unf_cnt", stack_cnt, 4'd0);
        check("unf_err", unf_err, 1'b1);
        check("ovf_sticky", ovf_err, 1'b1);

        // 5: interrupt entry, stall, clr during stall
        load = 1; new_addr = 12'h123; step();
        irq_take = 1; ret = 1; step();
        check("irq_pc", pc, 12'h001);
        check("irq_top", stack_top, 12'h123);
        check("irq_cnt", stack_cnt, 4'd1);
        stall = 1; call = 1; new_addr = 12'h777; step();
        check("stall_pc", pc, 12'h001);
        check("stall_cnt", stack_cnt, 4'd1);
        stall = 1; clr = 1; inc = 1; step();
        check("clr_pc", pc, 12'h000);
        check("clr_cnt", stack_cnt, 4'd0);
        check("clr_errs", {ovf_err, unf_err}, 2'b00);
        check("clr_top", stack_top, 12'h000);

        // 6: asynchronous reset mid-sequence
        ret = 1; step();
        check("unf2_err", unf_err, 1'b1);
        load = 1; new_addr = 12'h040; step();
        call = 1; new_addr = 12'h100; step();
        call = 1; new_addr = 12'h200; step();
        call = 1; new_addr = 12'h300; step();
        check("pre_rst_cnt", stack_cnt, 4'd3);
        check("pre_rst_pc", pc, 12'h300);
        #2;
        reset = 1;
        #1;
        check("arst_pc", pc, 12'h000);
        check("arst_cnt", stack_cnt, 4'd0);
        check("arst_errs", {ovf_err, unf_err}, 2'b00);
        check("arst_empty", stack_empty, 1'b1);
        step();
        reset = 0;
        inc = 1; step();
        check("post_rst_inc", pc, 12'h001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
